// File: rtl/exe_stage.sv
// Execute stage: operand forwarding muxes, ALU, NZCV status register and EXE/MEM pipeline register.
// Optional macro EXE_FORWARDING_EN enables the val1/val2/ST_val forwarding selects.
module exe_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        flush,
  input  logic [3:0]  exe_cmd,
  input  logic        s_en,
  input  logic        imm,
  input  logic [31:0] imm32,
  input  logic [31:0] val_rn,
  input  logic [31:0] val_rm,
  input  logic [31:0] st_val,
  input  logic [1:0]  val1_sel,
  input  logic [1:0]  val2_sel,
  input  logic [1:0]  ST_val_sel,
  input  logic [31:0] alu_res_fwd_MEM,
  input  logic [31:0] wb_value_WB,
  input  logic [3:0]  dest_EXE,
  input  logic        wb_en_EXE,
  input  logic        mem_r_en_EXE,
  input  logic        mem_w_en_EXE,
  output logic [31:0] alu_res_MEM,
  output logic [31:0] st_val_MEM,
  output logic [3:0]  dest_MEM,
  output logic        wb_en_MEM,
  output logic        mem_r_en_MEM,
  output logic        mem_w_en_MEM,
  output logic [3:0]  status
);

  typedef enum logic [3:0] {
    OP_MOV = 4'b0001,
    OP_ADD = 4'b0010,
    OP_ADC = 4'b0011,
    OP_SUB = 4'b0100,
    OP_SBC = 4'b0101,
    OP_AND = 4'b0110,
    OP_ORR = 4'b0111,
    OP_EOR = 4'b1000,
    OP_MVN = 4'b1001
  } alu_op_e;

  logic [31:0] op1, op2_reg, op2, st_data;

`ifdef EXE_FORWARDING_EN
  function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                          input logic [31:0] id_v,
                                          input logic [31:0] mem_v,
                                          input logic [31:0] wb_v);
    case (sel)
      2'b01:   return mem_v;
      2'b10:   return wb_v;
      default: return id_v;
    endcase
  endfunction

  assign op1     = fwd_mux(val1_sel,   val_rn, alu_res_fwd_MEM, wb_value_WB);
  assign op2_reg = fwd_mux(val2_sel,   val_rm, alu_res_fwd_MEM, wb_value_WB);
  assign st_data = fwd_mux(ST_val_sel, st_val, alu_res_fwd_MEM, wb_value_WB);
`else
  logic unused_fwd;
  assign unused_fwd = ^{val1_sel, val2_sel, ST_val_sel, alu_res_fwd_MEM, wb_value_WB};
  assign op1     = val_rn;
  assign op2_reg = val_rm;
  assign st_data = st_val;
`endif

  assign op2 = imm ? imm32 : op2_reg;

  alu_op_e     op;
  logic [31:0] alu_res;
  logic [32:0] sum33;
  logic        c_in, flag_c, flag_v, op_valid;

  assign op   = alu_op_e'(exe_cmd);
  assign c_in = status[1];

  // Subtraction is done as a true 33-bit difference; C is the inverted borrow.
  always_comb begin
    alu_res  = '0;
    sum33    = '0;
    flag_c   = status[1];
    flag_v   = status[0];
    op_valid = 1'b1;
    case (op)
      OP_MOV: alu_res = op2;
      OP_MVN: alu_res = ~op2;
      OP_ADD, OP_ADC: begin
        sum33   = {1'b0, op1} + {1'b0, op2} + {32'b0, (op == OP_ADC) & c_in};
        alu_res = sum33[31:0];
        flag_c  = sum33[32];
        flag_v  = (op1[31] == op2[31]) && (alu_res[31] != op1[31]);
      end
      OP_SUB, OP_SBC: begin
        sum33   = {1'b0, op1} - {1'b0, op2} - {32'b0, (op == OP_SBC) & ~c_in};
        alu_res = sum33[31:0];
        flag_c  = ~sum33[32];
        flag_v  = (op1[31] != op2[31]) && (alu_res[31] != op1[31]);
      end
      OP_AND: alu_res = op1 & op2;
      OP_ORR: alu_res = op1 | op2;
      OP_EOR: alu_res = op1 ^ op2;
      default: op_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status <= '0;
    end else if (s_en && op_valid && !freeze && !flush) begin
      status <= {alu_res[31], (alu_res == 32'd0), flag_c, flag_v};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_res_MEM  <= '0;
      st_val_MEM   <= '0;
      dest_MEM     <= '0;
      wb_en_MEM    <= 1'b0;
      mem_r_en_MEM <= 1'b0;
      mem_w_en_MEM <= 1'b0;
    end else if (flush) begin
      alu_res_MEM  <= '0;
      st_val_MEM   <= '0;
      dest_MEM     <= '0;
      wb_en_MEM    <= 1'b0;
      mem_r_en_MEM <= 1'b0;
      mem_w_en_MEM <= 1'b0;
    end else if (!freeze) begin
      alu_res_MEM  <= alu_res;
      st_val_MEM   <= st_data;
      dest_MEM     <= dest_EXE;
      wb_en_MEM    <= wb_en_EXE;
      mem_r_en_MEM <= mem_r_en_EXE;
      mem_w_en_MEM <= mem_w_en_EXE;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage; expectations follow EXE_FORWARDING_EN if it is defined.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze, flush, s_en, imm;
  logic [3:0]  exe_cmd, dest_EXE;
  logic [31:0] imm32, val_rn, val_rm, st_val, alu_res_fwd_MEM, wb_value_WB;
  logic [1:0]  val1_sel, val2_sel, ST_val_sel;
  logic        wb_en_EXE, mem_r_en_EXE, mem_w_en_EXE;
  logic [31:0] alu_res_MEM, st_val_MEM;
  logic [3:0]  dest_MEM, status;
  logic        wb_en_MEM, mem_r_en_MEM, mem_w_en_MEM;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  exe_stage dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .exe_cmd(exe_cmd), .s_en(s_en), .imm(imm), .imm32(imm32),
    .val_rn(val_rn), .val_rm(val_rm), .st_val(st_val),
    .val1_sel(val1_sel), .val2_sel(val2_sel), .ST_val_sel(ST_val_sel),
    .alu_res_fwd_MEM(alu_res_fwd_MEM), .wb_value_WB(wb_value_WB),
    .dest_EXE(dest_EXE), .wb_en_EXE(wb_en_EXE),
    .mem_r_en_EXE(mem_r_en_EXE), .mem_w_en_EXE(mem_w_en_EXE),
    .alu_res_MEM(alu_res_MEM), .st_val_MEM(st_val_MEM), .dest_MEM(dest_MEM),
    .wb_en_MEM(wb_en_MEM), .mem_r_en_MEM(mem_r_en_MEM),
    .mem_w_en_MEM(mem_w_en_MEM), .status(status)
  );

  always #5 clk = ~clk;

`ifdef EXE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                        input logic se);
    exe_cmd = cmd; val_rn = rn; val_rm = rm; s_en = se;
  endtask

  initial begin
    rst_n = 1'b0; freeze = 1'b0; flush = 1'b0; imm = 1'b0; imm32 = 32'h0000_1234;
    set_op(4'b0010, 32'h11, 32'h22, 1'b0);
    st_val = 32'h5555_5555; alu_res_fwd_MEM = 32'h7; wb_value_WB = 32'h9;
    val1_sel = 2'b00; val2_sel = 2'b00; ST_val_sel = 2'b00;
    dest_EXE = 4'd3; wb_en_EXE = 1'b1; mem_r_en_EXE = 1'b1; mem_w_en_EXE = 1'b1;
    #2;
    chk("rst_res",    alu_res_MEM, 32'h0);
    chk("rst_status", {28'h0, status}, 32'h0);

    // load nonzero state, then async reset mid-cycle
    rst_n = 1'b1;
    tick();
    chk("load_res",  alu_res_MEM, 32'h33);
    chk("load_ctrl", {dest_MEM, wb_en_MEM, mem_r_en_MEM, mem_w_en_MEM}, {25'h0, 4'd3, 3'b111});
    #2 rst_n = 1'b0;
    #1;
    chk("arst_res",  alu_res_MEM, 32'h0);
    chk("arst_st",   st_val_MEM, 32'h0);
    chk("arst_ctrl", {dest_MEM, wb_en_MEM, mem_r_en_MEM, mem_w_en_MEM}, 32'h0);
    chk("arst_stat", {28'h0, status}, 32'h0);
    rst_n = 1'b1;
    wb_en_EXE = 1'b0; mem_r_en_EXE = 1'b0; mem_w_en_EXE = 1'b0;

    // forwarding
    set_op(4'b0010, 32'd5, 32'd3, 1'b0);
    val1_sel = 2'b01;
    tick();
    chk("add_fwd_mem", alu_res_MEM, FWD ? 32'd10 : 32'd8);
    val2_sel = 2'b10;
    tick();
    chk("add_fwd_wb", alu_res_MEM, FWD ? 32'd16 : 32'd8);
    val1_sel = 2'b11; val2_sel = 2'b11;
    tick();
    chk("add_sel11", alu_res_MEM, 32'd8);
    val1_sel = 2'b00; val2_sel = 2'b00;

    // flags
    set_op(4'b0100, 32'h8000_0000, 32'h1, 1'b1);
    tick();
    chk("sub_res",  alu_res_MEM, 32'h7FFF_FFFF);
    chk("sub_nzcv", {28'h0, status}, 32'b0011);
    set_op(4'b0011, 32'd1, 32'd1, 1'b0);
    tick();
    chk("adc_res",  alu_res_MEM, 32'd3);
    chk("adc_nzcv", {28'h0, status}, 32'b0011);

    // flush and freeze together
    set_op(4'b0010, 32'd0, 32'd0, 1'b1);
    wb_en_EXE = 1'b1; dest_EXE = 4'd7; flush = 1'b1; freeze = 1'b1;
    tick();
    chk("ff_wb_en", {31'h0, wb_en_MEM}, 32'h0);
    chk("ff_dest",  {28'h0, dest_MEM}, 32'h0);
    chk("ff_nzcv",  {28'h0, status}, 32'b0011);
    flush = 1'b0; freeze = 1'b0;

    // freeze hold for 3 cycles
    set_op(4'b0010, 32'd2, 32'd3, 1'b0);
    dest_EXE = 4'd5;
    tick();
    chk("pre_frz_res", alu_res_MEM, 32'd5);
    set_op(4'b0010, 32'd100, 32'd1, 1'b1);
    dest_EXE = 4'd9; wb_en_EXE = 1'b0; freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_res",  alu_res_MEM, 32'd5);
      chk("frz_ctrl", {24'h0, dest_MEM, 3'b000, wb_en_MEM}, {24'h0, 4'd5, 4'b0001});
      chk("frz_nzcv", {28'h0, status}, 32'b0011);
    end
    freeze = 1'b0;
    tick();
    chk("unfrz_res",  alu_res_MEM, 32'd101);
    chk("unfrz_nzcv", {28'h0, status}, 32'b0000);

    // store forwarding
    set_op(4'b0001, 32'd0, 32'd0, 1'b0);
    mem_w_en_EXE = 1'b1; ST_val_sel = 2'b10;
    wb_value_WB = 32'hDEAD_BEEF; st_val = 32'h1111_1111;
    tick();
    chk("st_fwd",   st_val_MEM, FWD ? 32'hDEAD_BEEF : 32'h1111_1111);
    chk("st_w_en",  {31'h0, mem_w_en_MEM}, 32'h1);
    mem_w_en_EXE = 1'b0; ST_val_sel = 2'b00;

    // flag boundaries
    set_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1);
    tick();
    chk("add_ovf_res",  alu_res_MEM, 32'h8000_0000);
    chk("add_ovf_nzcv", {28'h0, status}, 32'b1001);
    set_op(4'b1111, 32'd4, 32'd4, 1'b1);
    tick();
    chk("bad_cmd_res",  alu_res_MEM, 32'h0);
    chk("bad_cmd_nzcv", {28'h0, status}, 32'b1001);
    set_op(4'b0101, 32'd5, 32'd3, 1'b1);
    tick();
    chk("sbc_res",  alu_res_MEM, 32'd1);
    chk("sbc_nzcv", {28'h0, status}, 32'b0010);
    set_op(4'b0010, 32'hFFFF_FFFF, 32'h1, 1'b1);
    tick();
    chk("add_carry_res",  alu_res_MEM, 32'h0);
    chk("add_carry_nzcv", {28'h0, status}, 32'b0110);
    set_op(4'b1001, 32'd0, 32'hFFFF_FFFF, 1'b1);
    imm = 1'b1; imm32 = 32'h0;
    tick();
    chk("mvn_imm_res",  alu_res_MEM, 32'hFFFF_FFFF);
    chk("mvn_imm_nzcv", {28'h0, status}, 32'b1010);
    imm = 1'b0;
    set_op(4'b1000, 32'hF0F0_00FF, 32'h0F0F_00F0, 1'b0);
    tick();
    chk("eor_res", alu_res_MEM, 32'hFFFF_000F);
    set_op(4'b0110, 32'hF0F0_00FF, 32'h0F0F_00F0, 1'b0);
    tick();
    chk("and_res", alu_res_MEM, 32'h0000_00F0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
